// File: rtl/aplic_idc_scheduler.sv
// APLIC per-hart IDC scheduler: scans sources for the best eligible interrupt, publishes topi, drives Xeip.
// Optional macro APLIC_IDC_IFORCE_EN adds the iforce input and the o_iforce_clr pulse.
module aplic_idc_scheduler #(
    parameter int NR_SRC        = 32,
    parameter int PRIO_W        = 6,
    parameter int SRC_PER_CYCLE = 4
) (
    input  logic                     i_clk,
    input  logic                     ni_rst,
    input  logic [NR_SRC-1:0]        i_pending,
    input  logic [NR_SRC-1:0]        i_enabled,
    input  logic [NR_SRC-1:0]        i_target_hit,
    input  logic [NR_SRC*PRIO_W-1:0] i_prio,
    input  logic                     i_idelivery,
    input  logic [PRIO_W-1:0]        i_ithreshold,
    input  logic                     i_claim,
    output logic [$clog2(NR_SRC)-1:0] o_topi_id,
    output logic [PRIO_W-1:0]        o_topi_prio,
    output logic                     o_clr_valid,
    output logic [$clog2(NR_SRC)-1:0] o_clr_id,
    output logic                     o_xeip
`ifdef APLIC_IDC_IFORCE_EN
    ,
    input  logic                     i_iforce,
    output logic                     o_iforce_clr
`endif
);

    localparam int ID_W    = $clog2(NR_SRC);
    localparam int NR_STEP = NR_SRC / SRC_PER_CYCLE;
    localparam int CNT_W   = (NR_STEP > 1) ? $clog2(NR_STEP) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   nxt_id;
    logic [PRIO_W-1:0] nxt_prio;
    logic [PRIO_W-1:0] prio_arr [NR_SRC];
    logic              force_line;

`ifdef APLIC_IDC_IFORCE_EN
    assign force_line = i_iforce;
`else
    assign force_line = 1'b0;
`endif

    // Priority 0 is not a legal level; it ranks like priority 1.
    function automatic logic [PRIO_W-1:0] eff_prio(input logic [PRIO_W-1:0] p);
        return (p == '0) ? PRIO_W'(1) : p;
    endfunction

    always_comb begin
        for (int s = 0; s < NR_SRC; s++) begin
            prio_arr[s] = eff_prio(i_prio[s*PRIO_W +: PRIO_W]);
        end
    end

    // Candidates are visited in ascending id with strict less-than, so ties keep the lower id.
    always_comb begin : pick
        logic [ID_W-1:0]   sid;
        logic [PRIO_W-1:0] p;
        nxt_id   = best_id;
        nxt_prio = best_prio;
        sid      = '0;
        p        = '0;
        for (int k = 0; k < SRC_PER_CYCLE; k++) begin
            sid = ID_W'(int'(cnt) * SRC_PER_CYCLE + k);
            p   = prio_arr[sid];
            if (sid != '0 && i_pending[sid] && i_enabled[sid] && i_target_hit[sid] &&
                (i_ithreshold == '0 || p < i_ithreshold) &&
                (nxt_id == '0 || p < nxt_prio)) begin
                nxt_id   = sid;
                nxt_prio = p;
            end
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            best_id     <= '0;
            best_prio   <= '0;
            o_topi_id   <= '0;
            o_topi_prio <= '0;
            o_clr_valid <= 1'b0;
            o_clr_id    <= '0;
            o_xeip      <= 1'b0;
`ifdef APLIC_IDC_IFORCE_EN
            o_iforce_clr <= 1'b0;
`endif
        end else begin
            o_clr_valid <= 1'b0;
            o_xeip      <= i_idelivery && (o_topi_id != '0 || force_line);
`ifdef APLIC_IDC_IFORCE_EN
            o_iforce_clr <= 1'b0;
`endif
            if (i_claim) begin
                // Claim aborts the pass so a winner found before the claim is never published.
                o_clr_valid <= (o_topi_id != '0);
                o_clr_id    <= o_topi_id;
`ifdef APLIC_IDC_IFORCE_EN
                o_iforce_clr <= (o_topi_id == '0) && i_iforce;
`endif
                o_topi_id   <= '0;
                o_topi_prio <= '0;
                best_id     <= '0;
                best_prio   <= '0;
                state       <= SCAN;
                cnt         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                    SCAN: begin
                        best_id   <= nxt_id;
                        best_prio <= nxt_prio;
                        if (cnt == CNT_W'(NR_STEP - 1)) begin
                            state <= UPDATE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    UPDATE: begin
                        o_topi_id   <= best_id;
                        o_topi_prio <= best_prio;
                        best_id     <= '0;
                        best_prio   <= '0;
                        state       <= SCAN;
                        cnt         <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aplic_idc_scheduler.sv
// Directed bench for aplic_idc_scheduler: vector table for selection rules, hand sequences for timing and claims.
module tb_aplic_idc_scheduler;

    localparam int NR_SRC        = 32;
    localparam int PRIO_W        = 6;
    localparam int SRC_PER_CYCLE = 4;
    localparam int ID_W          = 5;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NR_SRC-1:0]        pending;
    logic [NR_SRC-1:0]        enabled;
    logic [NR_SRC-1:0]        target_hit;
    logic [NR_SRC*PRIO_W-1:0] prio;
    logic                     idelivery;
    logic [PRIO_W-1:0]        ithreshold;
    logic                     claim;
    logic [ID_W-1:0]          topi_id;
    logic [PRIO_W-1:0]        topi_prio;
    logic                     clr_valid;
    logic [ID_W-1:0]          clr_id;
    logic                     xeip;
`ifdef APLIC_IDC_IFORCE_EN
    logic                     iforce;
    logic                     iforce_clr;
`endif

    int checks = 0;
    int errors = 0;

    aplic_idc_scheduler #(
        .NR_SRC(NR_SRC), .PRIO_W(PRIO_W), .SRC_PER_CYCLE(SRC_PER_CYCLE)
    ) dut (
        .i_clk(clk),
        .ni_rst(rst_n),
        .i_pending(pending),
        .i_enabled(enabled),
        .i_target_hit(target_hit),
        .i_prio(prio),
        .i_idelivery(idelivery),
        .i_ithreshold(ithreshold),
        .i_claim(claim),
        .o_topi_id(topi_id),
        .o_topi_prio(topi_prio),
        .o_clr_valid(clr_valid),
        .o_clr_id(clr_id),
        .o_xeip(xeip)
`ifdef APLIC_IDC_IFORCE_EN
        ,
        .i_iforce(iforce),
        .o_iforce_clr(iforce_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pend;
        logic [31:0] en;
        logic [31:0] hit;
        int          sa;
        int          pa;
        int          sb;
        int          pb;
        int          thr;
        logic        idel;
        int          eid;
        int          ep;
        logic        ex;
    } vec_t;

    vec_t vt [13];

    function automatic logic [31:0] m2(input int a, input int b);
        logic [31:0] r;
        r    = '0;
        r[a] = 1'b1;
        r[b] = 1'b1;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        pending    = v.pend;
        enabled    = v.en;
        target_hit = v.hit;
        prio       = '0;
        prio[v.sa*PRIO_W +: PRIO_W] = PRIO_W'(v.pa);
        prio[v.sb*PRIO_W +: PRIO_W] = PRIO_W'(v.pb);
        ithreshold = PRIO_W'(v.thr);
        idelivery  = v.idel;
    endtask

    initial begin
        // pend, en, hit, sa, pa, sb, pb, thr, idel, exp id, exp prio, exp xeip
        vt[0]  = '{32'h0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 1'b1, 0, 0, 1'b0};
        vt[1]  = '{m2(5,9), m2(5,9), m2(5,9), 5, 3, 9, 3, 0, 1'b1, 5, 3, 1'b1};
        vt[2]  = '{m2(7,7), m2(7,7), m2(7,7), 7, 2, 7, 2, 2, 1'b1, 0, 0, 1'b0};
        vt[3]  = '{m2(7,7), m2(7,7), m2(7,7), 7, 2, 7, 2, 3, 1'b1, 7, 2, 1'b1};
        vt[4]  = '{m2(12,20), m2(12,20), m2(12,20), 12, 0, 20, 1, 0, 1'b1, 12, 1, 1'b1};
        vt[5]  = '{m2(12,20), m2(12,20), m2(12,20), 12, 5, 20, 1, 0, 1'b1, 20, 1, 1'b1};
        vt[6]  = '{m2(5,9), m2(5,9), m2(5,9), 5, 3, 9, 3, 0, 1'b0, 5, 3, 1'b0};
        vt[7]  = '{m2(5,9), m2(9,9), m2(5,9), 5, 1, 9, 3, 0, 1'b1, 9, 3, 1'b1};
        vt[8]  = '{m2(5,9), m2(5,9), m2(9,9), 5, 1, 9, 3, 0, 1'b1, 9, 3, 1'b1};
        vt[9]  = '{m2(0,31), m2(0,31), m2(0,31), 0, 1, 31, 63, 0, 1'b1, 31, 63, 1'b1};
        vt[10] = '{m2(3,29), m2(3,29), m2(3,29), 3, 4, 29, 2, 0, 1'b1, 29, 2, 1'b1};
        vt[11] = '{m2(4,6), m2(4,6), m2(4,6), 6, 2, 4, 2, 0, 1'b1, 4, 2, 1'b1};
        vt[12] = '{m2(10,10), m2(10,10), m2(10,10), 10, 62, 10, 62, 63, 1'b1, 10, 62, 1'b1};

        claim = 1'b0;
        load(vt[0]);
`ifdef APLIC_IDC_IFORCE_EN
        iforce = 1'b0;
`endif
        step(2);
        chk("rst_topi_id", int'(topi_id), 0);
        chk("rst_topi_prio", int'(topi_prio), 0);
        chk("rst_clr_valid", int'(clr_valid), 0);
        chk("rst_clr_id", int'(clr_id), 0);
        chk("rst_xeip", int'(xeip), 0);

        // First pass timing: IDLE exit at edge 1, topi latched at edge 10, xeip at 11.
        load(vt[1]);
        rst_n = 1'b1;
        step(9);
        chk("pre_update_id", int'(topi_id), 0);
        step(1);
        chk("first_update_id", int'(topi_id), 5);
        chk("first_update_prio", int'(topi_prio), 3);
        chk("xeip_lag", int'(xeip), 0);
        step(1);
        chk("xeip_set", int'(xeip), 1);

        // Claim sampled at edge 19, which is the second UPDATE cycle.
        step(7);
        claim = 1'b1;
        pending[5] = 1'b0;
        step(1);
        claim = 1'b0;
        chk("claim_clr_valid", int'(clr_valid), 1);
        chk("claim_clr_id", int'(clr_id), 5);
        chk("claim_topi_id", int'(topi_id), 0);
        step(1);
        chk("clr_pulse_end", int'(clr_valid), 0);
        chk("claim_xeip_low", int'(xeip), 0);
        step(7);
        chk("no_stale_id", int'(topi_id), 0);
        step(1);
        chk("next_best_id", int'(topi_id), 9);
        chk("next_best_prio", int'(topi_prio), 3);

        // Back-to-back claims: only the first produces a clear.
        step(1);
        claim = 1'b1;
        step(1);
        chk("b2b_first_valid", int'(clr_valid), 1);
        chk("b2b_first_id", int'(clr_id), 9);
        step(1);
        claim = 1'b0;
        chk("b2b_second_valid", int'(clr_valid), 0);
        chk("b2b_topi_id", int'(topi_id), 0);

        for (int i = 0; i < 13; i++) begin
            load(vt[i]);
            step(30);
            chk($sformatf("vec%0d_id", i), int'(topi_id), vt[i].eid);
            chk($sformatf("vec%0d_prio", i), int'(topi_prio), vt[i].ep);
            chk($sformatf("vec%0d_xeip", i), int'(xeip), int'(vt[i].ex));
        end

`ifdef APLIC_IDC_IFORCE_EN
        load(vt[0]);
        iforce = 1'b1;
        step(30);
        chk("iforce_xeip", int'(xeip), 1);
        claim = 1'b1;
        step(1);
        claim = 1'b0;
        chk("iforce_clr_pulse", int'(iforce_clr), 1);
        chk("iforce_clr_valid", int'(clr_valid), 0);
        step(1);
        chk("iforce_clr_end", int'(iforce_clr), 0);
        iforce = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
